// File: rtl/meas_sequencer.sv
// meas_sequencer: schedules bursts of ADC conversions, averages them and scales the mean to mV.
// Optional per-burst min/max tracking is built when MEAS_SEQ_MINMAX_EN is defined.
module meas_sequencer #(
  parameter int unsigned SAMPLE_PERIOD_CYC = 100_000,
  parameter int unsigned AVG_LOG2          = 4,
  parameter logic [7:0]  SCALE_0F8         = 8'd206,
  parameter int unsigned TIMEOUT_CYC       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_trig_i,
  input  logic        cont_en_i,
  output logic        adc_start_o,
  input  logic        adc_busy_i,
  input  logic        adc_done_i,
  input  logic [11:0] adc_data_i,
  output logic [11:0] result_raw_o,
  output logic [11:0] result_mv_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [11:0] min_raw_o,
  output logic [11:0] max_raw_o
);

  localparam int DATA_W = 12;
  localparam int COEF_W = 8;
  localparam int ACC_W  = DATA_W + int'(AVG_LOG2);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = int'(AVG_LOG2) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int PER_W  = $clog2(SAMPLE_PERIOD_CYC);
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1) << AVG_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SCALE, S_OUT} state_t;

  state_t              state, state_nxt;
  logic                start_go, done_go, tmo_hit, tick;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PER_W-1:0]    per_cnt;
  logic [DATA_W-1:0]   avg_p1, mv_p1;

  function automatic logic [DATA_W-1:0] avg_code(input logic [ACC_W-1:0] sum);
    return DATA_W'(sum >> AVG_LOG2);
  endfunction

  // Truncating 0.8 fixed-point scale; the product never exceeds 4079 after the shift.
  function automatic logic [DATA_W-1:0] scale_mv(input logic [DATA_W-1:0] code);
    return DATA_W'((PROD_W'(code) * PROD_W'(SCALE_0F8)) >> COEF_W);
  endfunction

  assign busy_o = (state != S_IDLE);
  assign tick   = cont_en_i && (per_cnt == PER_W'(SAMPLE_PERIOD_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !cont_en_i) per_cnt <= '0;
    else if (tick)         per_cnt <= '0;
    else                   per_cnt <= per_cnt + PER_W'(1);
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    done_go   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE:  if (meas_trig_i || tick) state_nxt = S_START;
      S_START: if (!adc_busy_i) begin
        start_go  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done_i) begin
          done_go   = 1'b1;
          state_nxt = (cnt + CNT_W'(1) == N_SAMPLES) ? S_SCALE : S_START;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SCALE: state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      adc_start_o    <= 1'b0;
      result_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
      tmo_cnt        <= '0;
      cnt            <= '0;
      acc            <= '0;
      avg_p1         <= '0;
      mv_p1          <= '0;
      result_raw_o   <= '0;
      result_mv_o    <= '0;
    end else begin
      state          <= state_nxt;
      adc_start_o    <= start_go;
      result_valid_o <= (state == S_OUT);
      if (state == S_IDLE && state_nxt == S_START) begin
        acc       <= '0;
        cnt       <= '0;
        timeout_o <= 1'b0;
      end
      if (start_go)
        tmo_cnt <= TMO_W'(TIMEOUT_CYC);
      else if (state == S_WAIT && !adc_done_i && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      if (tmo_hit) timeout_o <= 1'b1;
      // Stage p0: accumulate accepted samples
      if (done_go) begin
        acc <= acc + ACC_W'(adc_data_i);
        cnt <= cnt + CNT_W'(1);
      end
      // Stage p1: average and scale
      if (state == S_SCALE) begin
        avg_p1 <= avg_code(acc);
        mv_p1  <= scale_mv(avg_code(acc));
      end
      // Stage p2: publish results
      if (state == S_OUT) begin
        result_raw_o <= avg_p1;
        result_mv_o  <= mv_p1;
      end
    end
  end

`ifdef MEAS_SEQ_MINMAX_EN
  logic [DATA_W-1:0] min_acc, max_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_acc   <= '0;
      max_acc   <= '0;
      min_raw_o <= '0;
      max_raw_o <= '0;
    end else begin
      // First sample of a burst seeds both trackers
      if (done_go) begin
        if (cnt == '0 || adc_data_i < min_acc) min_acc <= adc_data_i;
        if (cnt == '0 || adc_data_i > max_acc) max_acc <= adc_data_i;
      end
      if (state == S_OUT) begin
        min_raw_o <= min_acc;
        max_raw_o <= max_acc;
      end
    end
  end
`else
  assign min_raw_o = '0;
  assign max_raw_o = '0;
`endif

endmodule
